// File: rtl/fifo_port_scheduler.sv
// Shares one FIFO write/read port pair between NREQ round-robin writers and a single reader.
// Define FIFO_SCHED_RD_PRIO_EN to let reads always win write/read contention.
module fifo_port_scheduler #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned LW   = $clog2(DEPTH) + 1,
    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    wr_req,
    input  logic [NREQ*DW-1:0] wr_data,
    output logic [NREQ-1:0]    wr_gnt,
    input  logic               rd_req,
    output logic               rd_gnt,
    output logic               rd_valid,
    output logic               fifo_wr,
    output logic               fifo_rd,
    output logic [DW-1:0]      fifo_din,
    input  logic               fifo_full,
    input  logic               fifo_empty,
    output logic [LW-1:0]      level,
    output logic               sync_err
);

    typedef enum logic {OpRead, OpWrite} op_e;

    op_e           last_op;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] idx;
    logic [PW-1:0] rr_next;
    logic          gnt_found;
    logic          can_wr;
    logic          can_rd;
    logic          do_wr;
    logic          do_rd;
    logic          flag_mismatch;

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_idx   = '0;
        gnt_found = 1'b0;
        idx       = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = PW'((32'(rr_ptr) + 32'(k)) % NREQ);
            if (!gnt_found && wr_req[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_comb begin
        can_wr = (|wr_req) && !fifo_full;
        can_rd = rd_req && !fifo_empty;
`ifdef FIFO_SCHED_RD_PRIO_EN
        do_rd  = can_rd;
        do_wr  = can_wr && !can_rd;
`else
        do_rd  = can_rd && (!can_wr || last_op == OpWrite);
        do_wr  = can_wr && (!can_rd || last_op == OpRead);
`endif
        if (rst) begin
            do_rd = 1'b0;
            do_wr = 1'b0;
        end
    end

    always_comb begin
        wr_gnt   = '0;
        fifo_din = '0;
        if (do_wr) begin
            wr_gnt[gnt_idx] = 1'b1;
            fifo_din        = wr_data[32'(gnt_idx)*DW +: DW];
        end
    end

    assign fifo_wr = do_wr;
    assign fifo_rd = do_rd;
    assign rd_gnt  = do_rd;
    assign rr_next = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    assign flag_mismatch = ((level == LW'(DEPTH)) != fifo_full) || ((level == '0) != fifo_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            level    <= '0;
            rr_ptr   <= '0;
            last_op  <= OpRead;
            rd_valid <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (flag_mismatch) begin
                sync_err <= 1'b1;
            end
            if (do_wr) begin
                rr_ptr  <= rr_next;
                last_op <= OpWrite;
                if (level != LW'(DEPTH)) begin
                    level <= level + 1'b1;
                end
            end else if (do_rd) begin
                last_op <= OpRead;
                if (level != '0) begin
                    level <= level - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_port_scheduler.sv
// Bench for fifo_port_scheduler: queue-based FIFO environment plus a rule-level reference model.
module tb_fifo_port_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wr_req;
    logic [31:0] wr_data;
    logic [3:0]  wr_gnt;
    logic        rd_req;
    logic        rd_gnt;
    logic        rd_valid;
    logic        fifo_wr;
    logic        fifo_rd;
    logic [7:0]  fifo_din;
    logic        fifo_full;
    logic        fifo_empty;
    logic [4:0]  level;
    logic        sync_err;

    fifo_port_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .rd_req     (rd_req),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .fifo_wr    (fifo_wr),
        .fifo_rd    (fifo_rd),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .level      (level),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Environment FIFO and reference model state
    logic [7:0] fq[$];
    logic [7:0] mq[$];
    logic [7:0] dout = 8'h00;
    logic [7:0] wdat [4];
    logic       ovr_en  = 1'b0;
    logic       ovr_val = 1'b0;
    int         m_level, m_ptr;
    logic       m_last_wr, m_rd_valid, m_sync;
    logic [7:0] m_dout;

    logic [3:0] cap_gnt;
    logic       cap_wr, cap_rd, cap_rdg, cap_rdv, cap_sync;
    logic [7:0] cap_din;
    int         cap_level;

    function automatic void check(string nm, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    task automatic step(input logic r, input logic [3:0] req, input logic rv);
        logic       e_wr, e_rd, cw, cr, found;
        logic [3:0] e_gnt;
        logic [7:0] e_din;
        int         g;
        rst    = r;
        wr_req = req;
        rd_req = rv;
        for (int i = 0; i < 4; i++) wr_data[i*8 +: 8] = wdat[i];
        fifo_full  = (fq.size() == 16);
        fifo_empty = ovr_en ? ovr_val : (fq.size() == 0);
        e_wr = 1'b0; e_rd = 1'b0; e_gnt = 4'b0; e_din = 8'h00; g = 0; found = 1'b0;
        if (!r) begin
            cw = (req != 4'b0) && !fifo_full;
            cr = rv && !fifo_empty;
`ifdef FIFO_SCHED_RD_PRIO_EN
            e_rd = cr;
            e_wr = cw && !cr;
`else
            if (cw && cr) begin
                if (m_last_wr) e_rd = 1'b1;
                else           e_wr = 1'b1;
            end else begin
                e_wr = cw;
                e_rd = cr;
            end
`endif
            if (e_wr) begin
                for (int k = 0; k < 4; k++) begin
                    if (!found && req[(m_ptr + k) % 4]) begin
                        found = 1'b1;
                        g     = (m_ptr + k) % 4;
                    end
                end
                e_gnt = 4'b0001 << g;
                e_din = wdat[g];
            end
        end
        #3;
        check("wr_gnt", wr_gnt, e_gnt);
        check("fifo_wr", fifo_wr, e_wr);
        check("fifo_din", fifo_din, e_din);
        check("fifo_rd", fifo_rd, e_rd);
        check("rd_gnt", rd_gnt, e_rd);
        check("level", level, m_level);
        check("rd_valid", rd_valid, m_rd_valid);
        check("sync_err", sync_err, m_sync);
        if (m_rd_valid) check("dout", dout, m_dout);
        cap_gnt = wr_gnt; cap_wr = fifo_wr; cap_rd = fifo_rd; cap_rdg = rd_gnt;
        cap_din = fifo_din; cap_level = level; cap_rdv = rd_valid; cap_sync = sync_err;
        @(posedge clk);
        if (r) begin
            fq.delete();
        end else begin
            if (cap_wr && fq.size() < 16) fq.push_back(cap_din);
            if (cap_rd && fq.size() > 0) dout = fq.pop_front();
        end
        if (r) begin
            m_level = 0; m_ptr = 0; m_last_wr = 1'b0; m_rd_valid = 1'b0; m_sync = 1'b0;
            mq.delete();
        end else begin
            if (((m_level == 16) != fifo_full) || ((m_level == 0) != fifo_empty)) m_sync = 1'b1;
            m_rd_valid = e_rd;
            if (e_wr) begin
                mq.push_back(e_din);
                m_level++;
                m_ptr     = (g + 1) % 4;
                m_last_wr = 1'b1;
            end
            if (e_rd) begin
                m_dout    = (mq.size() > 0) ? mq.pop_front() : 8'h00;
                m_level--;
                m_last_wr = 1'b0;
            end
        end
        #1;
    endtask

    typedef struct {
        logic       r;
        logic [3:0] req;
        logic       rv;
        logic [3:0] gnt;
        logic       rdg;
        logic [7:0] din;
        int         lvl;
    } vec_t;

    vec_t tbl [12];
    int   ops [6];
    int   exp_ops [6];
    logic [3:0] pend;

    initial begin
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 0};
        tbl[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, 8'hA5, 0};
        tbl[2]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1};
        tbl[3]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 8'hA5, 0};
        tbl[4]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0, 8'h11, 1};
        tbl[5]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b0, 8'h12, 2};
        tbl[6]  = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0, 8'h13, 3};
        tbl[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 8'hA5, 4};
        tbl[8]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0, 8'h11, 5};
        tbl[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b0, 8'h12, 6};
        tbl[10] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0, 8'h13, 7};
        tbl[11] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 8};
        wdat[0] = 8'hA5; wdat[1] = 8'h11; wdat[2] = 8'h12; wdat[3] = 8'h13;
        m_level = 0; m_ptr = 0; m_last_wr = 1'b0; m_rd_valid = 1'b0; m_sync = 1'b0; m_dout = 8'h00;
        rst = 1'b1; wr_req = 4'b0; rd_req = 1'b0; wr_data = 32'h0;
        fifo_full = 1'b0; fifo_empty = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].req, tbl[i].rv);
            check($sformatf("tbl%0d_gnt", i), cap_gnt, tbl[i].gnt);
            check($sformatf("tbl%0d_rdg", i), cap_rdg, tbl[i].rdg);
            check($sformatf("tbl%0d_din", i), cap_din, tbl[i].din);
            check($sformatf("tbl%0d_lvl", i), cap_level, tbl[i].lvl);
        end

        // Fill to 16, then a held write must stall; then read back the oldest entry.
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0001, 1'b0);
        step(1'b0, 4'b0001, 1'b0);
        check("full_lvl", cap_level, 16);
        check("full_gnt", cap_gnt, 0);
        check("full_wr", cap_wr, 0);
        step(1'b0, 4'b0000, 1'b1);
        check("full_rdg", cap_rdg, 1);
        step(1'b0, 4'b0000, 1'b0);
        check("first_rdv", cap_rdv, 1);
        check("first_dout", dout, 8'hA5);
        check("first_lvl", cap_level, 15);

        // Contention from level 4 with last op a read.
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0001, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b0100, 1'b1);
            ops[i] = cap_wr ? 1 : (cap_rd ? 2 : 0);
        end
`ifdef FIFO_SCHED_RD_PRIO_EN
        exp_ops = '{2, 2, 2, 2, 1, 1};
`else
        exp_ops = '{1, 2, 1, 2, 1, 2};
`endif
        for (int i = 0; i < 6; i++) check($sformatf("contend_op%0d", i), ops[i], exp_ops[i]);
        step(1'b0, 4'b0000, 1'b0);
`ifdef FIFO_SCHED_RD_PRIO_EN
        check("contend_lvl", cap_level, 2);
`else
        check("contend_lvl", cap_level, 4);
`endif

        // Empty read is refused; a forged non-empty flag latches sync_err until reset.
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        check("empty_rdg", cap_rdg, 0);
        check("empty_rd", cap_rd, 0);
        step(1'b0, 4'b0000, 1'b0);
        check("sync_clean", cap_sync, 0);
        ovr_en = 1'b1; ovr_val = 1'b0;
        step(1'b0, 4'b0000, 1'b0);
        ovr_en = 1'b0;
        step(1'b0, 4'b0000, 1'b0);
        check("sync_set", cap_sync, 1);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        check("sync_sticky", cap_sync, 1);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        check("sync_cleared", cap_sync, 0);

        // Reset in the middle of traffic.
        for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        check("rst_wr", cap_wr, 0);
        check("rst_rd", cap_rd, 0);
        check("rst_gnt", cap_gnt, 0);
        step(1'b0, 4'b1111, 1'b1);
        check("post_rst_lvl", cap_level, 0);
        check("post_rst_rdv", cap_rdv, 0);
        check("post_rst_gnt", cap_gnt, 4'b0001);

        // Randomized traffic; requesters hold req/data until granted.
        pend = 4'b0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    wdat[i] = 8'($urandom);
                end
            end
            step(($urandom_range(0, 63) == 0), pend, ($urandom_range(0, 99) < 40));
            pend = pend & ~cap_gnt;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
